// File: rtl/dummy_pkg.sv
// Shared types for the coprocessor issue arbiter: control word, grant index, FSM states.
package dummy_pkg;

  localparam int unsigned NUM_REQ_DEF      = 2;
  localparam int unsigned MAX_INFLIGHT_DEF = 4;
  localparam int unsigned GRANT_IDX_W      = 3;

  typedef logic [GRANT_IDX_W-1:0] grant_idx_t;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] mode;
    logic       sign;
  } coproc_ctl_t;

  // Next round-robin priority index after a grant to idx, wrapping at n.
  function automatic grant_idx_t rr_next(input grant_idx_t idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) return '0;
    return idx + grant_idx_t'(1);
  endfunction

endpackage

// File: rtl/dummy_arb_fifo.sv
// In-order ID FIFO recording which requester owns each outstanding coprocessor operation.
module dummy_arb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PTR_W-1:0]            wr_ptr_q;
  logic [PTR_W-1:0]            rd_ptr_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        push_ok;
  logic                        pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dummy_arb.sv
// Round-robin issue arbiter for a shared coprocessor with in-order result routing.
// Optional per-requester grant counters are built when DUMMY_ARB_PERF_EN is defined.
module dummy_arb
  import dummy_pkg::*;
#(
  parameter int unsigned NUM_REQ      = NUM_REQ_DEF,
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int unsigned PAYLOAD_W    = 64,
  parameter int unsigned RES_W        = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic        [NUM_REQ-1:0]           req_valid_i,
  output logic        [NUM_REQ-1:0]           req_ready_o,
  input  coproc_ctl_t [NUM_REQ-1:0]           req_ctl_i,
  input  logic        [NUM_REQ-1:0][PAYLOAD_W-1:0] req_payload_i,
  output logic                                cp_valid_o,
  input  logic                                cp_ready_i,
  output coproc_ctl_t                         cp_ctl_o,
  output logic        [PAYLOAD_W-1:0]         cp_payload_o,
  input  logic                                cp_valid_i,
  output logic                                cp_ready_o,
  input  logic        [RES_W-1:0]             cp_res_i,
  output logic        [NUM_REQ-1:0]           resp_valid_o,
  input  logic        [NUM_REQ-1:0]           resp_ready_i,
  output logic        [RES_W-1:0]             resp_data_o,
  output logic        [$clog2(MAX_INFLIGHT):0] inflight_o,
  output logic                                busy_o,
  output logic        [NUM_REQ-1:0][15:0]     perf_grant_o
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;

  arb_state_e           state_q, state_d;
  grant_idx_t           rr_ptr_q;
  grant_idx_t           hold_idx_q;
  coproc_ctl_t          hold_ctl_q;
  logic [PAYLOAD_W-1:0] hold_payload_q;
  logic                 hold_load;

  logic                 arb_found;
  grant_idx_t           arb_idx;
  coproc_ctl_t          arb_ctl;
  logic [PAYLOAD_W-1:0] arb_payload;
  grant_idx_t           grant_idx;
  logic                 issue_fire;

  logic                 fifo_full;
  logic                 fifo_empty;
  grant_idx_t           fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 head_ok;
  logic                 head_ready;
  logic                 result_pop;

  // First pass covers indices at/after the pointer, second pass wraps to the lowest valid.
  always_comb begin : arb_select
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && req_valid_i[i] && (grant_idx_t'(i) >= rr_ptr_q)) begin
        arb_found = 1'b1;
        arb_idx   = grant_idx_t'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && req_valid_i[i]) begin
        arb_found = 1'b1;
        arb_idx   = grant_idx_t'(i);
      end
    end
  end

  always_comb begin : arb_operands
    arb_ctl     = '0;
    arb_payload = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == grant_idx_t'(i)) begin
        arb_ctl     = req_ctl_i[i];
        arb_payload = req_payload_i[i];
      end
    end
  end

  // Issue FSM; HOLD replays registered operands so the coprocessor sees a stable request.
  always_comb begin : fsm_comb
    state_d      = state_q;
    hold_load    = 1'b0;
    cp_valid_o   = 1'b0;
    grant_idx    = arb_idx;
    cp_ctl_o     = '0;
    cp_payload_o = '0;
    case (state_q)
      ST_ARB: begin
        if (!flush_i && !fifo_full && arb_found) begin
          cp_valid_o   = 1'b1;
          cp_ctl_o     = arb_ctl;
          cp_payload_o = arb_payload;
          if (!cp_ready_i) begin
            state_d   = ST_HOLD;
            hold_load = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        grant_idx = hold_idx_q;
        if (flush_i) begin
          state_d = ST_ARB;
        end else begin
          cp_valid_o   = 1'b1;
          cp_ctl_o     = hold_ctl_q;
          cp_payload_o = hold_payload_q;
          if (cp_ready_i) state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign issue_fire = cp_valid_o && cp_ready_i;

  always_comb begin : req_ready_gen
    req_ready_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = cp_valid_o && cp_ready_i && (grant_idx == grant_idx_t'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_ARB;
      rr_ptr_q       <= '0;
      hold_idx_q     <= '0;
      hold_ctl_q     <= '0;
      hold_payload_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        rr_ptr_q <= '0;
      end else if (issue_fire) begin
        rr_ptr_q <= rr_next(grant_idx, NUM_REQ);
      end
      if (hold_load) begin
        hold_idx_q     <= arb_idx;
        hold_ctl_q     <= arb_ctl;
        hold_payload_q <= arb_payload;
      end
    end
  end

  dummy_arb_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (GRANT_IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (issue_fire),
    .data_i  (grant_idx),
    .pop_i   (result_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Results are steered to the requester that owns the oldest outstanding operation.
  assign head_ok = !fifo_empty && !flush_i;

  always_comb begin : head_route
    head_ready   = 1'b0;
    resp_valid_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (fifo_head == grant_idx_t'(i)) begin
        head_ready      = resp_ready_i[i];
        resp_valid_o[i] = head_ok && cp_valid_i;
      end
    end
  end

  assign cp_ready_o  = head_ok && head_ready;
  assign result_pop  = cp_valid_i && cp_ready_o;
  assign resp_data_o = fifo_empty ? '0 : cp_res_i;
  assign inflight_o  = fifo_count;
  assign busy_o      = (fifo_count != '0) || cp_valid_o;

`ifdef DUMMY_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] perf_q;

  // Saturating accepted-issue counters per requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (flush_i) begin
      perf_q <= '0;
    end else if (issue_fire) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if ((grant_idx == grant_idx_t'(i)) && (perf_q[i] != 16'hFFFF)) begin
          perf_q[i] <= perf_q[i] + 16'd1;
        end
      end
    end
  end

  assign perf_grant_o = perf_q;
`else
  assign perf_grant_o = '0;
`endif

endmodule

// File: doc/dummy_arb.md
DUMMY_ARB -- requirements
Module: dummy_arb

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing the coprocessor (2..8).
REQ-002 Parameter MAX_INFLIGHT, default 4: ID FIFO depth, i.e. issued-but-unanswered operations (power of 2, >=2).
REQ-003 Parameter PAYLOAD_W, default 64; parameter RES_W, default 32.
REQ-004 clk_i  in  1  clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  synchronous abort of all outstanding work.
REQ-007 req_valid_i / req_ready_o  in / out  NUM_REQ  per-requester issue handshake.
REQ-008 req_ctl_i  in  NUM_REQ x dummy_pkg::coproc_ctl_t  requested mode; req_payload_i  in  NUM_REQ x PAYLOAD_W  operands.
REQ-009 cp_valid_o / cp_ready_i  out / in  1  issue handshake towards coprocessor; cp_ctl_o  out  coproc_ctl_t; cp_payload_o  out  PAYLOAD_W.
REQ-010 cp_valid_i / cp_ready_o  in / out  1  result handshake from coprocessor; cp_res_i  in  RES_W.
REQ-011 resp_valid_o / resp_ready_i  out / in  NUM_REQ  per-requester result handshake; resp_data_o  out  RES_W, shared by all requesters.
REQ-012 inflight_o  out  $clog2(MAX_INFLIGHT)+1  outstanding count; busy_o  out  1  inflight_o!=0 or cp_valid_o.

Function
REQ-013 FSM states: ARB (no issue pending) and HOLD (cp_valid_o high, not yet accepted).
REQ-014 In ARB, if the ID FIFO is not full and any req_valid_i is high, grant round-robin, assert cp_valid_o the same cycle (combinational path), and drive cp_ctl_o/cp_payload_o from the winner.
REQ-015 Round-robin: highest priority goes to the index after the last accepted grant; the pointer updates only on cp_valid_o&&cp_ready_i; the pointer resets to 0, giving requester 0 highest priority.
REQ-016 In ARB with cp_ready_i low, the FSM moves to HOLD and registers the grant index; in HOLD, the grant, cp_ctl_o and cp_payload_o stay fixed until cp_ready_i, then it returns to ARB.
REQ-017 req_ready_o[i] equals cp_ready_i for the granted index only; every other bit is 0.
REQ-018 Each accepted issue pushes the grant index into the ID FIFO.
REQ-019 When the FIFO is full (registered), no grant is made, even if a pop occurs in the same cycle.
REQ-020 Results return in issue order: resp_valid_o[head]=cp_valid_i and FIFO non-empty; all other resp_valid_o bits are 0; resp_data_o=cp_res_i.
REQ-021 cp_ready_o = resp_ready_i[head] and FIFO non-empty; each accepted result pops one entry.
REQ-022 cp_valid_i with an empty FIFO is ignored: cp_ready_o=0 and no resp_valid_o.
REQ-023 A push and a pop in the same cycle leave the count unchanged; the FIFO pointers wrap modulo MAX_INFLIGHT.
REQ-024 flush_i empties the FIFO, forces ARB, resets the pointer to 0, and deasserts cp_valid_o, all req_ready_o, cp_ready_o and resp_valid_o that cycle; the coprocessor is flushed in parallel by its own flush_i.

Reset
REQ-025 On reset, the FSM is in ARB, the FIFO is empty, and the pointer is 0.
REQ-026 On reset, every output is 0 (all valid/ready signals, inflight_o, busy_o, and the data outputs).
REQ-027 Reset assertion mid-transaction discards HOLD state and all FIFO contents immediately (asynchronous).

Configuration
REQ-028 Macro DUMMY_ARB_PERF_EN defined: output perf_grant_o (NUM_REQ x 16) holds per-requester counts of accepted issues; counters saturate at 16'hFFFF and clear on reset and on flush_i.
REQ-029 Macro DUMMY_ARB_PERF_EN undefined: perf_grant_o still exists, is tied to 0, and no counter flops are instantiated.

Structure
REQ-030 NUM_REQ/MAX_INFLIGHT defaults, the grant-index typedef and the FSM state enum belong in dummy_pkg, alongside coproc_ctl_t.
REQ-031 The ID FIFO is the sub-module dummy_arb_fifo (parameters DEPTH and WIDTH; push/pop/full/empty/count ports); the arbiter and FSM stay in dummy_arb.

Verification
REQ-032 Req0 and req1 valid every cycle, cp_ready_i=1 -> grants alternate 0,1,0,1; FIFO holds {0,1,0,1} after 4 issues; 5th issue stalls until the first result pop.
REQ-033 Req1 valid, cp_ready_i=0 for 3 cycles -> HOLD with grant=1; payload stable; req0 raised during HOLD gets no ready; accept on cycle 4.
REQ-034 Issue from req1 then req0; results R1, R2 -> resp_valid_o[1] with R1, then resp_valid_o[0] with R2; resp_ready_i[1]=0 for 2 cycles stalls cp_ready_o.
REQ-035 FIFO full, same-cycle result pop and pending request -> no grant that cycle; grant next cycle; inflight_o 4->3->4.
REQ-036 flush_i with 3 outstanding, one in HOLD -> next cycle inflight_o=0, cp_valid_o=0, pointer 0; cp_valid_i afterwards is not acknowledged.
REQ-037 With DUMMY_ARB_PERF_EN, 70000 grants to req0 -> perf_grant_o[0]=16'hFFFF; without the macro, perf_grant_o stays 0.
